// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: broadcast packet layout, lane count and index helpers.
// The packet fields line up with the ROB completion inputs so the CDB can drive them directly.
package cdb_arbiter_pkg;

   localparam int unsigned PHYS_REG_BITS = 6;
   localparam int unsigned CDB_WIDTH     = 3;

   typedef struct packed {
      logic                     cdb_valid1;
      logic                     cdb_valid2;
      logic                     cdb_valid3;
      logic [PHYS_REG_BITS-1:0] cdb_tag1;
      logic [PHYS_REG_BITS-1:0] cdb_tag2;
      logic [PHYS_REG_BITS-1:0] cdb_tag3;
   } cdb_packet;

   // Increment with explicit wrap, so ring sizes need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after i_start, wrapping
// at NumFu. Returns the winner one-hot, a found flag and the winner index.
module cdb_arbiter_rr_pick #(
   parameter int unsigned NumFu = 8
) (
   input  logic [NumFu-1:0]         i_req,
   input  logic [$clog2(NumFu)-1:0] i_start,
   output logic [NumFu-1:0]         o_onehot,
   output logic                     o_found,
   output logic [$clog2(NumFu)-1:0] o_idx
);

   localparam int unsigned IdxW = $clog2(NumFu);

   always_comb begin
      int unsigned      pos;
      logic [IdxW-1:0]  pos_idx;
      o_onehot = '0;
      o_found  = 1'b0;
      o_idx    = '0;
      pos      = 0;
      pos_idx  = '0;
      for (int unsigned k = 0; k < NumFu; k++) begin
         pos = 32'(i_start) + k;
         if (pos >= NumFu) pos = pos - NumFu;
         pos_idx = IdxW'(pos);
         if (!o_found && i_req[pos_idx]) begin
            o_found           = 1'b1;
            o_idx             = pos_idx;
            o_onehot[pos_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB scheduler: grants up to three requesting FUs per cycle in rotating order and
// broadcasts their tags one cycle later on the registered three-lane CDB.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = 8
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NUM_FU-1:0]                     fu_req,
   input  logic [NUM_FU-1:0][PHYS_REG_BITS-1:0]  fu_tag,
   output logic [NUM_FU-1:0]                     fu_grant,
   output cdb_packet                             cdb_out
);

   localparam int unsigned PtrW = $clog2(NUM_FU);

   logic [PtrW-1:0]          r_rr_ptr;
   logic [PtrW-1:0]          w_rr_ptr_d;
   cdb_packet                r_cdb;
   cdb_packet                w_cdb_d;

   logic [NUM_FU-1:0]        w_req1, w_req2, w_req3;
   logic [NUM_FU-1:0]        w_oh1, w_oh2, w_oh3;
   logic [CDB_WIDTH-1:0]     w_found;
   logic [PtrW-1:0]          w_idx1, w_idx2, w_idx3;

   // Reset masks requests so nothing is consumed while it is held.
   assign w_req1 = reset ? '0 : fu_req;
   assign w_req2 = w_req1 & ~w_oh1;
   assign w_req3 = w_req2 & ~w_oh2;

   cdb_arbiter_rr_pick #(.NumFu(NUM_FU)) u_pick1 (
      .i_req    (w_req1),
      .i_start  (r_rr_ptr),
      .o_onehot (w_oh1),
      .o_found  (w_found[0]),
      .o_idx    (w_idx1)
   );

   cdb_arbiter_rr_pick #(.NumFu(NUM_FU)) u_pick2 (
      .i_req    (w_req2),
      .i_start  (r_rr_ptr),
      .o_onehot (w_oh2),
      .o_found  (w_found[1]),
      .o_idx    (w_idx2)
   );

   cdb_arbiter_rr_pick #(.NumFu(NUM_FU)) u_pick3 (
      .i_req    (w_req3),
      .i_start  (r_rr_ptr),
      .o_onehot (w_oh3),
      .o_found  (w_found[2]),
      .o_idx    (w_idx3)
   );

   assign fu_grant = w_oh1 | w_oh2 | w_oh3;

   always_comb begin
      w_cdb_d            = '0;
      w_cdb_d.cdb_valid1 = w_found[0];
      w_cdb_d.cdb_valid2 = w_found[1];
      w_cdb_d.cdb_valid3 = w_found[2];
      if (w_found[0]) w_cdb_d.cdb_tag1 = fu_tag[w_idx1];
      if (w_found[1]) w_cdb_d.cdb_tag2 = fu_tag[w_idx2];
      if (w_found[2]) w_cdb_d.cdb_tag3 = fu_tag[w_idx3];
   end

   // Lanes fill densely, so the highest found lane holds the last grant.
   always_comb begin
      w_rr_ptr_d = r_rr_ptr;
      if (w_found[2]) begin
         w_rr_ptr_d = PtrW'(wrap_inc(32'(w_idx3), NUM_FU));
      end else if (w_found[1]) begin
         w_rr_ptr_d = PtrW'(wrap_inc(32'(w_idx2), NUM_FU));
      end else if (w_found[0]) begin
         w_rr_ptr_d = PtrW'(wrap_inc(32'(w_idx1), NUM_FU));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_cdb    <= '0;
      end else begin
         r_rr_ptr <= w_rr_ptr_d;
         r_cdb    <= w_cdb_d;
      end
   end

   assign cdb_out = r_cdb;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus constrained-random traffic
// compared against a scan-order reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 8;
   typedef logic [N-1:0][PHYS_REG_BITS-1:0] tagv_t;

   logic       clock;
   logic       reset;
   logic [N-1:0] fu_req;
   tagv_t      fu_tag;
   logic [N-1:0] fu_grant;
   cdb_packet  cdb_out;

   int         n_checks = 0;
   int         n_errors = 0;
   int         m_ptr    = 0;
   logic [N-1:0] obs_grant;
   cdb_packet  obs_cdb;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clock    (clock),
      .reset    (reset),
      .fu_req   (fu_req),
      .fu_tag   (fu_tag),
      .fu_grant (fu_grant),
      .cdb_out  (cdb_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic cdb_packet mk(input int n, input int a, input int b, input int c);
      cdb_packet p;
      p = '0;
      if (n >= 1) begin p.cdb_valid1 = 1'b1; p.cdb_tag1 = PHYS_REG_BITS'(a); end
      if (n >= 2) begin p.cdb_valid2 = 1'b1; p.cdb_tag2 = PHYS_REG_BITS'(b); end
      if (n >= 3) begin p.cdb_valid3 = 1'b1; p.cdb_tag3 = PHYS_REG_BITS'(c); end
      return p;
   endfunction

   // Reference: walk FUs from the pointer modulo N, take the first three requesters.
   task automatic model(input logic rst, input logic [N-1:0] req, input tagv_t tags,
                        output logic [N-1:0] g, output cdb_packet p, output int nptr);
      int lanes[$];
      int i;
      g    = '0;
      p    = '0;
      nptr = m_ptr;
      if (rst) begin
         nptr = 0;
         return;
      end
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (req[i] && lanes.size() < 3) lanes.push_back(i);
      end
      foreach (lanes[j]) g[lanes[j]] = 1'b1;
      p = mk(lanes.size(),
             lanes.size() > 0 ? int'(tags[lanes[0]]) : 0,
             lanes.size() > 1 ? int'(tags[lanes[1]]) : 0,
             lanes.size() > 2 ? int'(tags[lanes[2]]) : 0);
      if (lanes.size() > 0) nptr = (lanes[lanes.size()-1] + 1) % N;
   endtask

   task automatic run_cycle(input logic rst, input logic [N-1:0] req, input tagv_t tags);
      logic [N-1:0] eg;
      cdb_packet    ep;
      int           np;
      @(negedge clock);
      reset  = rst;
      fu_req = req;
      fu_tag = tags;
      #1;
      model(rst, req, tags, eg, ep, np);
      obs_grant = fu_grant;
      check("grant", 64'(fu_grant), 64'(eg));
      @(posedge clock);
      #1;
      obs_cdb = cdb_out;
      check("cdb", 64'(cdb_out), 64'(ep));
      m_ptr = np;
   endtask

   initial begin
      tagv_t        t;
      logic [N-1:0] req;
      int           cnt [N];
      int           last [N];
      int           maxgap [N];
      cdb_packet    burst_exp [4];

      reset  = 1'b1;
      fu_req = '0;
      fu_tag = '0;

      // Reset holds off all grants even with every FU requesting.
      for (int i = 0; i < N; i++) t[i] = PHYS_REG_BITS'(i + 1);
      for (int c = 0; c < 3; c++) run_cycle(1'b1, '1, t);
      check("rst_grant", 64'(obs_grant), 64'h0);
      check("rst_cdb", 64'(obs_cdb), 64'h0);
      run_cycle(1'b0, '1, t);
      check("rst_release", 64'(obs_grant), 64'h07);

      // Single request from FU2 at pointer 0.
      run_cycle(1'b1, '0, t);
      t[2] = PHYS_REG_BITS'(5);
      run_cycle(1'b0, 8'h04, t);
      check("single_grant", 64'(obs_grant), 64'h04);
      check("single_cdb", 64'(obs_cdb), 64'(mk(1, 5, 0, 0)));
      run_cycle(1'b0, '1, t);
      check("single_ptr3", 64'(obs_grant), 64'h38);

      // Burst drain, each FU dropping once granted.
      run_cycle(1'b1, '0, t);
      for (int i = 0; i < N; i++) t[i] = PHYS_REG_BITS'(10 + i);
      burst_exp[0] = mk(3, 10, 11, 12);
      burst_exp[1] = mk(3, 13, 14, 15);
      burst_exp[2] = mk(2, 16, 17, 0);
      burst_exp[3] = mk(0, 0, 0, 0);
      req = '1;
      for (int c = 0; c < 4; c++) begin
         run_cycle(1'b0, req, t);
         check($sformatf("burst_cdb%0d", c), 64'(obs_cdb), 64'(burst_exp[c]));
         req = req & ~obs_grant;
      end

      // Wrap-around from pointer 6.
      run_cycle(1'b1, '0, t);
      t = '0;
      run_cycle(1'b0, 8'h20, t);
      t[0] = PHYS_REG_BITS'(4);
      t[1] = PHYS_REG_BITS'(5);
      t[7] = PHYS_REG_BITS'(9);
      run_cycle(1'b0, 8'h83, t);
      check("wrap_grant", 64'(obs_grant), 64'h83);
      check("wrap_cdb", 64'(obs_cdb), 64'(mk(3, 9, 4, 5)));
      run_cycle(1'b0, '1, t);
      check("wrap_ptr2", 64'(obs_grant), 64'h1C);

      // Fairness under continuous full load.
      run_cycle(1'b1, '0, t);
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0; last[i] = 0; maxgap[i] = 0;
      end
      for (int c = 1; c <= 24; c++) begin
         run_cycle(1'b0, '1, t);
         for (int i = 0; i < N; i++) begin
            if (obs_grant[i]) begin
               cnt[i]++;
               if (c - last[i] > maxgap[i]) maxgap[i] = c - last[i];
               last[i] = c;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         check($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'd9);
         check($sformatf("fair_gap%0d", i), 64'(maxgap[i] <= 3), 64'd1);
      end

      // Random traffic obeying the hold-until-granted contract, with occasional resets.
      req = '0;
      obs_grant = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req[i] && !obs_grant[i])) begin
               req[i] = ($urandom_range(0, 99) < 60);
               t[i]   = PHYS_REG_BITS'($urandom);
            end
         end
         run_cycle($urandom_range(0, 39) == 0, req, t);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
